// File: rtl/core_types_pkg.sv
// Shared core types for the branch predictor.
//   UPPER_PC_TABLE_ENTRIES     : number of distinct upper-PC targets tracked
//   LOG_UPPER_PC_TABLE_ENTRIES : index width into the upper-PC table
//   UPPER_PC_WIDTH             : width of PC[31:15]
//   upper_pc_entry_t           : one table entry {valid, upper_PC}
package core_types_pkg;

  localparam int unsigned BTB_TARGET_WIDTH           = 14;
  localparam int unsigned UPPER_PC_TABLE_ENTRIES     = 8;
  localparam int unsigned LOG_UPPER_PC_TABLE_ENTRIES = $clog2(UPPER_PC_TABLE_ENTRIES);
  localparam int unsigned UPPER_PC_WIDTH             = 32 - BTB_TARGET_WIDTH - 1;

  typedef struct packed {
    logic                      valid;
    logic [UPPER_PC_WIDTH-1:0] upper_PC;
  } upper_pc_entry_t;

endpackage

// File: rtl/upper_pc_table_if.sv
// Bus between fetch/resolve logic and the upper-PC table.
//   read_valid / read_index          : fetch expand request
//   read_upper_PC                    : expanded upper PC, one cycle later
//   update0_valid / update0_target_full_PC : resolved-target compress request
//   update1_upper_PC_index / update1_miss  : compress result, one cycle later
// master = requester, slave = the table.
interface upper_pc_table_if;
  import core_types_pkg::*;

  logic                                  read_valid;
  logic [LOG_UPPER_PC_TABLE_ENTRIES-1:0] read_index;
  logic [UPPER_PC_WIDTH-1:0]             read_upper_PC;
  logic                                  update0_valid;
  logic [31:0]                           update0_target_full_PC;
  logic [LOG_UPPER_PC_TABLE_ENTRIES-1:0] update1_upper_PC_index;
  logic                                  update1_miss;

  modport master (
    output read_valid, read_index, update0_valid, update0_target_full_PC,
    input  read_upper_PC, update1_upper_PC_index, update1_miss
  );

  modport slave (
    input  read_valid, read_index, update0_valid, update0_target_full_PC,
    output read_upper_PC, update1_upper_PC_index, update1_miss
  );
endinterface

// File: rtl/plru_8way.sv
// 8-way tree pseudo-LRU.
//   clk, rst_n      : clock, async active-low reset (state cleared to 0)
//   touch0_valid_i / touch0_way_i : first touch this cycle
//   touch1_valid_i / touch1_way_i : second touch, applied after touch0
//   victim_way_o    : combinational victim from the current state
// Node n has children 2n+1 / 2n+2; a node bit of 0 points the victim left.
module plru_8way (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       touch0_valid_i,
  input  logic [2:0] touch0_way_i,
  input  logic       touch1_valid_i,
  input  logic [2:0] touch1_way_i,
  output logic [2:0] victim_way_o
);

  logic [6:0] state_q, state_d, state_t0;

  // Point every node on the way's path away from that way.
  function automatic logic [6:0] touch(input logic [6:0] s, input logic [2:0] w);
    logic [6:0]  r;
    int unsigned n1, n2;
    r     = s;
    n1    = 1 + int'(w[2]);
    n2    = 3 + int'(w[2:1]);
    r[0]  = ~w[2];
    r[n1] = ~w[1];
    r[n2] = ~w[0];
    return r;
  endfunction

  always_comb begin
    state_t0 = state_q;
    if (touch0_valid_i) state_t0 = touch(state_q, touch0_way_i);
    state_d = state_t0;
    if (touch1_valid_i) state_d = touch(state_t0, touch1_way_i);
  end

  always_comb begin
    logic        b0, b1, b2;
    int unsigned n1, n2;
    b0           = state_q[0];
    n1           = 1 + int'(b0);
    b1           = state_q[n1];
    n2           = 3 + int'({b0, b1});
    b2           = state_q[n2];
    victim_way_o = {b0, b1, b2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= '0;
    else        state_q <= state_d;
  end

endmodule

// File: rtl/upper_pc_table.sv
// Upper-PC table: maps the 8 distinct PC[31:15] values in use to a 3-bit
// index so BTB/RAS entries only store PC[14:1].
//   CLK  : clock, posedge
//   nRST : async active-low reset
//   bus  : upper_pc_table_if.slave
//     read side   : read_valid/read_index -> read_upper_PC (1 cycle)
//     update side : update0_valid/update0_target_full_PC ->
//                   update1_upper_PC_index/update1_miss (1 cycle)
module upper_pc_table (
  input  logic               CLK,
  input  logic               nRST,
  upper_pc_table_if.slave    bus
);
  import core_types_pkg::*;

  localparam int unsigned ENT = UPPER_PC_TABLE_ENTRIES;
  localparam int unsigned LOG = LOG_UPPER_PC_TABLE_ENTRIES;

  upper_pc_entry_t           table_q [ENT];
  logic [UPPER_PC_WIDTH-1:0] read_upper_PC_q;
  logic [LOG-1:0]            update1_idx_q;
  logic                      update1_miss_q;

  logic [UPPER_PC_WIDTH-1:0] upd_upper;
  logic [ENT-1:0]            hit_vec;
  logic                      hit, any_invalid;
  logic [LOG-1:0]            hit_idx, free_idx, victim_idx, chosen_idx;
  logic                      unused_low_pc;

  assign upd_upper     = bus.update0_target_full_PC[31:15];
  assign unused_low_pc = ^bus.update0_target_full_PC[14:0];

  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    for (int unsigned i = 0; i < ENT; i++) begin
      hit_vec[i] = table_q[i].valid && (table_q[i].upper_PC == upd_upper);
      if (hit_vec[i]) hit_idx = LOG'(i);
    end
    hit = |hit_vec;
  end

  // Scan downward so the lowest invalid way is the last assignment.
  always_comb begin
    any_invalid = 1'b0;
    free_idx    = '0;
    for (int unsigned i = ENT; i > 0; i--) begin
      if (!table_q[i-1].valid) begin
        any_invalid = 1'b1;
        free_idx    = LOG'(i - 1);
      end
    end
  end

  always_comb begin
    if (hit)              chosen_idx = hit_idx;
    else if (any_invalid) chosen_idx = free_idx;
    else                  chosen_idx = victim_idx;
  end

  // Allocation only happens on a miss, so two matches cannot coexist.
  always_comb begin
    if (nRST && bus.update0_valid) assert ($onehot0(hit_vec));
  end

  plru_8way u_plru (
    .clk            (CLK),
    .rst_n          (nRST),
    .touch0_valid_i (bus.read_valid),
    .touch0_way_i   (bus.read_index),
    .touch1_valid_i (bus.update0_valid),
    .touch1_way_i   (chosen_idx),
    .victim_way_o   (victim_idx)
  );

  // Reads sample table_q before this edge's write: read-before-write.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < ENT; i++) table_q[i] <= '0;
      read_upper_PC_q <= '0;
      update1_idx_q   <= '0;
      update1_miss_q  <= 1'b0;
    end else begin
      if (bus.read_valid) read_upper_PC_q <= table_q[bus.read_index].upper_PC;
      if (bus.update0_valid) begin
        update1_idx_q <= chosen_idx;
        if (!hit) begin
          table_q[chosen_idx].valid    <= 1'b1;
          table_q[chosen_idx].upper_PC <= upd_upper;
        end
      end
      update1_miss_q <= bus.update0_valid && !hit;
    end
  end

  assign bus.read_upper_PC          = read_upper_PC_q;
  assign bus.update1_upper_PC_index = update1_idx_q;
  assign bus.update1_miss           = update1_miss_q;

endmodule

// File: tb/tb_upper_pc_table.sv
// Scoreboard bench for upper_pc_table: expected results are queued when a
// request is driven and checked when the DUT output appears a cycle later.
module tb_upper_pc_table;
  import core_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  upper_pc_table_if bus ();

  upper_pc_table dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [16:0] rd_q [$];
  logic [3:0]  up_q [$];   // {miss, index}
  logic [16:0] rd_hold;
  logic [2:0]  idx_hold;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pc_of(input int unsigned up);
    logic [16:0] u;
    u = up[16:0];
    return {u, 15'h0ace};
  endfunction

  // One request cycle; expected values are bench constants.
  task automatic cyc(input logic rv, input logic [2:0] ri, input logic uv,
                     input logic [31:0] pc, input logic [16:0] erd,
                     input logic [2:0] eidx, input logic emiss);
    logic [16:0] e_rd;
    logic [3:0]  e_up;
    bus.read_valid             = rv;
    bus.read_index             = ri;
    bus.update0_valid          = uv;
    bus.update0_target_full_PC = pc;
    if (rv) rd_q.push_back(erd);
    if (uv) up_q.push_back({emiss, eidx});
    @(posedge CLK); #1;
    bus.read_valid    = 1'b0;
    bus.update0_valid = 1'b0;
    if (rv) begin
      if (rd_q.size() == 0) chk("read_queue_empty", 32'd1, 32'd0);
      else begin
        e_rd = rd_q.pop_front();
        chk("read_upper_PC", 32'(bus.read_upper_PC), 32'(e_rd));
        rd_hold = e_rd;
      end
    end else chk("read_hold", 32'(bus.read_upper_PC), 32'(rd_hold));
    if (uv) begin
      if (up_q.size() == 0) chk("update_queue_empty", 32'd1, 32'd0);
      else begin
        e_up = up_q.pop_front();
        chk("update_index", 32'(bus.update1_upper_PC_index), 32'(e_up[2:0]));
        chk("update_miss", 32'(bus.update1_miss), 32'(e_up[3]));
        idx_hold = e_up[2:0];
      end
    end else begin
      chk("idle_miss", 32'(bus.update1_miss), 32'd0);
      chk("idle_index_hold", 32'(bus.update1_upper_PC_index), 32'(idx_hold));
    end
  endtask

  task automatic do_reset();
    bus.read_valid             = 1'b0;
    bus.read_index             = '0;
    bus.update0_valid          = 1'b0;
    bus.update0_target_full_PC = '0;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_read_upper_PC", 32'(bus.read_upper_PC), 32'd0);
    chk("rst_index", 32'(bus.update1_upper_PC_index), 32'd0);
    chk("rst_miss", 32'(bus.update1_miss), 32'd0);
    @(negedge CLK);
    nRST     = 1'b1;
    rd_hold  = '0;
    idx_hold = '0;
  endtask

  task automatic fill8();
    for (int unsigned k = 1; k <= 8; k++)
      cyc(1'b0, 3'd0, 1'b1, pc_of(k), 17'd0, 3'(k - 1), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cold fill and hit
    do_reset();
    cyc(1'b0, 3'd0, 1'b1, 32'h8000_4000, 17'd0, 3'd0, 1'b1);
    cyc(1'b1, 3'd0, 1'b0, 32'h0, 17'h10000, 3'd0, 1'b0);
    cyc(1'b0, 3'd0, 1'b1, 32'h8000_7FFE, 17'd0, 3'd0, 1'b0);
    cyc(1'b1, 3'd0, 1'b0, 32'h0, 17'h10000, 3'd0, 1'b0);
    cyc(1'b1, 3'd1, 1'b0, 32'h0, 17'h00000, 3'd0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 32'h0, 17'd0, 3'd0, 1'b0);

    // Eviction after a sequential fill: all PLRU bits point at way 0
    do_reset();
    fill8();
    cyc(1'b1, 3'd7, 1'b0, 32'h0, 17'd8, 3'd0, 1'b0);
    do_reset();
    fill8();
    cyc(1'b0, 3'd0, 1'b1, pc_of(9), 17'd0, 3'd0, 1'b1);
    cyc(1'b1, 3'd0, 1'b0, 32'h0, 17'd9, 3'd0, 1'b0);
    cyc(1'b0, 3'd0, 1'b1, pc_of(9), 17'd0, 3'd0, 1'b0);

    // Read-touch steers the victim to way 4
    do_reset();
    fill8();
    cyc(1'b1, 3'd0, 1'b0, 32'h0, 17'd1, 3'd0, 1'b0);
    cyc(1'b0, 3'd0, 1'b1, pc_of(10), 17'd0, 3'd4, 1'b1);
    cyc(1'b1, 3'd4, 1'b0, 32'h0, 17'd10, 3'd0, 1'b0);

    // Same-cycle read and allocate of way 2: old value, then new
    do_reset();
    cyc(1'b0, 3'd0, 1'b1, pc_of(1), 17'd0, 3'd0, 1'b1);
    cyc(1'b0, 3'd0, 1'b1, pc_of(2), 17'd0, 3'd1, 1'b1);
    cyc(1'b1, 3'd2, 1'b1, pc_of(3), 17'd0, 3'd2, 1'b1);
    cyc(1'b1, 3'd2, 1'b0, 32'h0, 17'd3, 3'd0, 1'b0);

    // Update touch wins the root: read 7 with update hit on way 0 -> victim 4
    do_reset();
    fill8();
    cyc(1'b1, 3'd7, 1'b1, pc_of(1), 17'd8, 3'd0, 1'b0);
    cyc(1'b0, 3'd0, 1'b1, pc_of(11), 17'd0, 3'd4, 1'b1);

    // Reset asserted during a miss update
    do_reset();
    cyc(1'b0, 3'd0, 1'b1, pc_of(1), 17'd0, 3'd0, 1'b1);
    cyc(1'b1, 3'd0, 1'b1, pc_of(2), 17'd1, 3'd1, 1'b1);
    bus.update0_valid          = 1'b1;
    bus.update0_target_full_PC = pc_of(31);
    #2;
    nRST = 1'b0;
    #1;
    chk("midrst_read_upper_PC", 32'(bus.read_upper_PC), 32'd0);
    chk("midrst_index", 32'(bus.update1_upper_PC_index), 32'd0);
    chk("midrst_miss", 32'(bus.update1_miss), 32'd0);
    @(posedge CLK); #1;
    chk("midrst_hold_miss", 32'(bus.update1_miss), 32'd0);
    bus.update0_valid = 1'b0;
    @(negedge CLK);
    nRST     = 1'b1;
    rd_hold  = '0;
    idx_hold = '0;
    cyc(1'b0, 3'd0, 1'b1, pc_of(31), 17'd0, 3'd0, 1'b1);
    cyc(1'b1, 3'd1, 1'b0, 32'h0, 17'd0, 3'd0, 1'b0);

    if (rd_q.size() != 0 || up_q.size() != 0) chk("scoreboard_drained", 32'd1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/upper_pc_table.md
# upper_pc_table

Upper-PC table for the branch predictor. BTB and RAS entries hold only a 14-bit target, PC[14:1]; this block holds the 8 distinct 17-bit upper targets, PC[31:15], and maps each to a 3-bit index.
- Update (write) side: runs at branch resolution. It compresses a full resolved target into an index, allocating an entry on a miss.
- Read side: runs at fetch. It expands an index back into the upper PC.
- The read side is the consumer of the indices the update side produces.

## Interface
Parameters (shared package):
- UPPER_PC_TABLE_ENTRIES, 8: entry count, must be a power of 2.
- LOG_UPPER_PC_TABLE_ENTRIES, $clog2(UPPER_PC_TABLE_ENTRIES) = 3: index width.
- UPPER_PC_WIDTH, 32 - BTB_TARGET_WIDTH - 1 = 17: upper PC width, PC[31:15].

Ports:
- CLK  input  1  clock, posedge.
- nRST  input  1  asynchronous, active-low reset.
- read_valid  input  1  fetch read request.
- read_index  input  3  entry to expand.
- read_upper_PC  output  17  upper PC of the entry read the previous cycle.
- update0_valid  input  1  resolved-target compress request.
- update0_target_full_PC  input  32  full target; bits [31:15] are used.
- update1_upper_PC_index  output  3  index assigned to the previous cycle's update.
- update1_miss  output  1  previous cycle's update allocated a new entry (perf counter).

## Operation
- State:
  - 8 entries, each valid (1 bit) + upper_PC (17 bits).
  - 7-bit tree PLRU. Node n has children 2n+1 and 2n+2; leaves map to ways 0..7 left to right; a node bit of 0 points the victim left.
- Read:
  - When read_valid=1, register upper_PC[read_index] into read_upper_PC.
  - Touch read_index in the PLRU.
  - When read_valid=0, read_upper_PC holds its value.
- Update, all decided within the cycle update0_valid=1:
  - CAM compare of PC[31:15] against every valid entry.
  - Hit: the index is the matching way; no write.
  - Miss, choosing the way to allocate: the lowest-index invalid entry if one exists, otherwise the PLRU victim, found by following the node bits from the root.
  - Miss, write: at the clock edge the chosen entry gets valid=1 and upper_PC=PC[31:15].
  - Either case: touch the chosen index. Register the index into update1_upper_PC_index and set update1_miss = !hit.
- PLRU touch of way w: each node on w's path is set to point to the side opposite w.
- Same-cycle read and update:
  - Apply the read touch first, then the update touch; the update wins on shared nodes.
  - A read of the entry being written returns the old contents (read-before-write).
- At most one matching entry can exist, because allocation only occurs on a miss. Multi-hit is unreachable; flag it with an assertion.

## Timing
- Read latency is 1 cycle. Update result latency is 1 cycle.
- A write is visible to both read and CAM on the next cycle, so back-to-back updates with the same upper PC hit on the second.
- When update0_valid=0:
  - update1_miss is 0 the next cycle.
  - update1_upper_PC_index holds its value.
- Reset, asynchronous, while nRST=0:
  - All valid bits, upper_PC fields and PLRU bits are 0.
  - read_upper_PC = 0, update1_upper_PC_index = 0, update1_miss = 0.
- Reset asserted mid-update discards the update; the first cycle after release behaves as after cold reset.
- No backpressure: both ports accept one request per cycle, always.

## Structure
- UPPER_PC_TABLE_ENTRIES, LOG_UPPER_PC_TABLE_ENTRIES and UPPER_PC_WIDTH live in core_types_pkg.
- Optional typedef for the entry: upper_pc_entry_t {valid, upper_PC}.
- One natural sub-module, plru_8way: combinational victim selection plus a sequential 7-bit state with two ordered touch ports. It is reused by the BTB and cache ways.

## Test plan
- Cold fill: reset, then update PC 0x8000_4000 -> next cycle index=0, miss=1. Read index 0 -> next cycle read_upper_PC=0x10000.
- Hit: update PC 0x8000_7FFE (same upper 0x10000) -> index=0, miss=0, entry unchanged.
- Eviction: fill 8 distinct upper PCs 0x00001..0x00008 into ways 0..7 in order, then update upper 0x00009 -> index=0, miss=1. Read 0 -> 0x00009.
- Read-touch steering: from the filled state, read index 0, then update a new upper PC -> PLRU victim is way 4 (not 0), miss=1.
- Same-cycle collision: read index 2 while an update allocates way 2 -> read_upper_PC returns the old value. A read the following cycle returns the new value. The update touch wins on the root bit.
- Reset mid-operation: assert nRST during a miss update -> all outputs 0. After release the same PC misses and allocates index 0.
